// File: rtl/nios2_cpu_div_cell_pkg.sv
// Shared types and constants for the Nios II iterative divider cell.
// Latencies assume the default 32-bit datapath.
package nios2_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    ITER  = 2'd2,
    FIXUP = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH         = 32;
  localparam int DIV_LATENCY       = DIV_WIDTH + 3;
  localparam int DIV_EARLY_LATENCY = 3;

  // Bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int bits;
    int rest;
    bits = 0;
    rest = value - 1;
    while (rest > 0) begin
      bits++;
      rest = rest >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/nios2_cpu_div_cell_if.sv
// Execute-stage operand/result bundle between the pipeline and the divider cell.
interface nios2_cpu_div_cell_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] E_src1;
  logic [WIDTH-1:0] E_src2;
  logic             start;
  logic             signed_op;
  logic             rem_op;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output E_src1, E_src2, start, signed_op, rem_op, abort,
    input  busy, done, result
  );

  modport slave (
    input  E_src1, E_src2, start, signed_op, rem_op, abort,
    output busy, done, result
  );

endinterface

// File: rtl/nios2_cpu_div_cell_step.sv
// One radix-2 restoring division iteration, purely combinational.
module nios2_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // rem < divisor keeps the shifted remainder below 2*divisor, so bit WIDTH of
  // the WIDTH+1 bit difference is a reliable borrow flag.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, divisor};
  assign rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/nios2_cpu_div_cell.sv
// Iterative restoring divider for div/divu and remainder forms.
// Optional macro NIOS2_DIV_EARLY_OUT_EN skips iteration when |src1| < |src2|.
module nios2_cpu_div_cell
  import nios2_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic               clk,
  input logic               reset,
  nios2_cpu_div_cell_if.slave bus
);

  localparam int CNT_W = clog2(WIDTH);

  div_state_t       state;
  div_state_t       state_nxt;

  logic [WIDTH-1:0] src1_q;
  logic [WIDTH-1:0] src2_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] count_q;
  logic             signed_q;
  logic             rem_op_q;
  logic             neg_q;
  logic             neg_r;
  logic             dz_q;
  logic             done_q;

  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             dz_nxt;
  logic             early_out;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  assign sign1  = signed_q & src1_q[WIDTH-1];
  assign sign2  = signed_q & src2_q[WIDTH-1];
  assign mag1   = sign1 ? -src1_q : src1_q;
  assign mag2   = sign2 ? -src2_q : src2_q;
  assign dz_nxt = (src2_q == '0);

`ifdef NIOS2_DIV_EARLY_OUT_EN
  assign early_out = ~dz_nxt & (mag1 < mag2);
`else
  assign early_out = 1'b0;
`endif

  nios2_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Divide-by-zero bypasses sign correction so both signednesses agree.
  assign fix_quo = dz_q ? '1     : (neg_q ? -quo_q : quo_q);
  assign fix_rem = dz_q ? src1_q : (neg_r ? -rem_q : rem_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = PREP;
        PREP:    state_nxt = early_out ? FIXUP : ITER;
        ITER:    if (count_q == CNT_W'(WIDTH - 1)) state_nxt = FIXUP;
        FIXUP:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath follows the registered state; an abort only needs to keep the
  // result and done quiet, since the next operation reloads everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src1_q   <= '0;
      src2_q   <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
      signed_q <= 1'b0;
      rem_op_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            src1_q   <= bus.E_src1;
            src2_q   <= bus.E_src2;
            signed_q <= bus.signed_op;
            rem_op_q <= bus.rem_op;
          end
        end
        PREP: begin
          dvs_q   <= mag2;
          neg_q   <= sign1 ^ sign2;
          neg_r   <= sign1;
          dz_q    <= dz_nxt;
          count_q <= '0;
          if (early_out) begin
            quo_q <= '0;
            rem_q <= mag1;
          end else begin
            quo_q <= mag1;
            rem_q <= '0;
          end
        end
        ITER: begin
          rem_q   <= step_rem;
          quo_q   <= step_quo;
          count_q <= count_q + 1'b1;
        end
        FIXUP: begin
          if (!bus.abort) begin
            result_q <= rem_op_q ? fix_rem : fix_quo;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
// Self-checking bench for nios2_cpu_div_cell: directed corner cases plus random
// operands against an arithmetic reference model.
module tb_nios2_cpu_div_cell;
  import nios2_div_pkg::*;

  localparam int W     = 32;
  localparam int LIMIT = 80;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  nios2_cpu_div_cell_if #(.WIDTH(W)) bus ();

  nios2_cpu_div_cell #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 64-bit arithmetic truncates toward zero and keeps the
  // remainder sign on the dividend; the low 32 bits give the wrapped result.
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic r);
    longint sa;
    longint sb;
    longint q;
    longint rm;
    if (b == '0) return r ? a : 32'hFFFF_FFFF;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q  = sa / sb;
    rm = sa % sb;
    return r ? rm[W-1:0] : q[W-1:0];
  endfunction

  function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
`ifdef NIOS2_DIV_EARLY_OUT_EN
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    ma = (s && a[W-1]) ? -a : a;
    mb = (s && b[W-1]) ? -b : b;
    if (b != '0 && ma < mb) return DIV_EARLY_LATENCY;
`else
    if (s && a == b) return DIV_LATENCY;
`endif
    return DIV_LATENCY;
  endfunction

  task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge; leaves the bench in cycle 1 of the operation.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic r);
    bus.E_src1    = a;
    bus.E_src2    = b;
    bus.signed_op = s;
    bus.rem_op    = r;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int first_cyc, output logic [W-1:0] res,
                           output int lat, output int busy_cycles);
    res         = '0;
    lat         = -1;
    busy_cycles = 0;
    for (int c = first_cyc; c <= LIMIT; c++) begin
      if (bus.done) begin
        lat = c;
        res = bus.result;
        break;
      end
      if (bus.busy) busy_cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input logic r, output logic [W-1:0] expect_res);
    logic [W-1:0] res;
    int           lat;
    int           bc;
    int           exp_lat;
    expect_res = ref_div(a, b, s, r);
    exp_lat    = ref_latency(a, b, s);
    apply_stimulus(a, b, s, r);
    wait_done(1, res, lat, bc);
    check_output({tag, " result"}, res, expect_res);
    check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, " busy cycles"}, 32'(bc), 32'(exp_lat - 1));
    check_output({tag, " busy in done cycle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    check_output(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [W-1:0] last_res;
    logic [W-1:0] exp_res;
    logic [W-1:0] res;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           lat;
    int           bc;

    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    bus.E_src1    = '0;
    bus.E_src2    = '0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.rem_op    = 1'b0;
    bus.abort     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset busy", 32'(bus.busy), 32'd0);
    check_output("reset done", 32'(bus.done), 32'd0);
    check_output("reset result", bus.result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_and_check("u 100/7 q", 32'd100, 32'd7, 1'b0, 1'b0, last_res);
    run_and_check("u 100/7 r", 32'd100, 32'd7, 1'b0, 1'b1, last_res);
    check_output("u 100/7 r const", last_res, 32'd2);
    run_and_check("s -7/2 q", -32'sd7, 32'd2, 1'b1, 1'b0, last_res);
    check_output("s -7/2 q const", last_res, 32'hFFFF_FFFD);
    run_and_check("s -7/2 r", -32'sd7, 32'd2, 1'b1, 1'b1, last_res);
    check_output("s -7/2 r const", last_res, 32'hFFFF_FFFF);
    run_and_check("s 7/-2 q", 32'd7, -32'sd2, 1'b1, 1'b0, last_res);
    run_and_check("s 7/-2 r", 32'd7, -32'sd2, 1'b1, 1'b1, last_res);
    check_output("s 7/-2 r const", last_res, 32'd1);
    run_and_check("dz s q", 32'h1234_5678, 32'd0, 1'b1, 1'b0, last_res);
    run_and_check("dz s r", 32'h1234_5678, 32'd0, 1'b1, 1'b1, last_res);
    run_and_check("dz u q", 32'h1234_5678, 32'd0, 1'b0, 1'b0, last_res);
    run_and_check("dz u r", 32'h1234_5678, 32'd0, 1'b0, 1'b1, last_res);
    check_output("dz u r const", last_res, 32'h1234_5678);
    run_and_check("s ovf q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, last_res);
    check_output("s ovf q const", last_res, 32'h8000_0000);
    run_and_check("s ovf r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, last_res);
    run_and_check("u ovf q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, last_res);
    run_and_check("u ovf r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, last_res);
    run_and_check("u 5/9 q", 32'd5, 32'd9, 1'b0, 1'b0, last_res);
    run_and_check("u 5/9 r", 32'd5, 32'd9, 1'b0, 1'b1, last_res);
    check_output("u 5/9 r const", last_res, 32'd5);

    // Abort during cycle 10; the earlier result must survive.
    @(posedge clk); #1;
    apply_stimulus(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_output("abort busy next cycle", 32'(bus.busy), 32'd0);
    watch_no_done("abort no done", 40);
    check_output("abort result held", bus.result, last_res);

    // Abort together with start in IDLE.
    bus.abort = 1'b1;
    apply_stimulus(32'd50, 32'd5, 1'b0, 1'b0);
    bus.abort = 1'b0;
    check_output("abort+start busy", 32'(bus.busy), 32'd0);
    watch_no_done("abort+start no done", 40);

    // Second start while busy is ignored.
    exp_res = ref_div(32'd100, 32'd7, 1'b0, 1'b0);
    apply_stimulus(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.E_src1 = 32'd1000;
    bus.E_src2 = 32'd10;
    bus.rem_op = 1'b1;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(6, res, lat, bc);
    check_output("busy start result", res, exp_res);
    check_output("busy start latency", 32'(lat), 32'(ref_latency(32'd100, 32'd7, 1'b0)));
    // A start in the done cycle launches immediately.
    run_and_check("start in done cycle", 32'd1000, 32'd10, 1'b0, 1'b0, last_res);
    watch_no_done("no extra done", 40);

    // Async reset mid-operation.
    apply_stimulus(32'd77, 32'd5, 1'b1, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    check_output("async reset busy", 32'(bus.busy), 32'd0);
    check_output("async reset result", bus.result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 255);
        2:       rb = -$urandom_range(1, 64);
        default: rb = (i % 8 == 0) ? 32'd0 : ra + $urandom_range(0, 9);
      endcase
      run_and_check($sformatf("rand %0d", i), ra, rb, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), last_res);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nios2_cpu_div_cell.md
Name: nios2_cpu_div_cell

Overview:
- Iterative radix-2 restoring divider for the Nios II execute stage.
- Counterpart to the pipelined multiplier cell: it implements div, divu and the remainder forms.
- Takes E-stage operands on a start pulse and holds the pipeline through busy.
- Returns a single registered 32-bit quotient or remainder with a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand and result width in bits (even, at least 4).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- E_src1  in  WIDTH  dividend.
- E_src2  in  WIDTH  divisor.
- start  in  1  request a divide; sampled only in IDLE.
- signed_op  in  1  1 = two's-complement divide, 0 = unsigned; captured with start.
- rem_op  in  1  1 = return remainder, 0 = return quotient; captured with start.
- abort  in  1  pipeline flush; cancels any operation in progress.
- busy  out  1  operation in progress (PREP, ITER or FIXUP).
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  WIDTH  quotient or remainder; held until the next done.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
- FSM states: IDLE, PREP, ITER, FIXUP.
- IDLE:
  - start=1 captures operands, signed_op and rem_op; next state PREP.
  - start while busy=1 is ignored.
- PREP (1 cycle):
  - Form magnitudes |src1| and |src2|, negating only when signed_op=1 and the MSB is set.
  - Record neg_q = sign1 XOR sign2 and neg_r = sign1.
  - Record dz = (src2 == 0).
  - Clear the partial remainder, load the quotient shift register with |src1|, set count=0.
  - Next state ITER.
- ITER (exactly WIDTH cycles):
  - Each cycle: shift {rem,quo} left by 1, then trial = rem - |src2| in WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quo LSB = 1. Otherwise keep rem and quo LSB = 0.
  - When count = WIDTH-1, next state FIXUP.
- FIXUP (1 cycle):
  - Quotient = neg_q ? -quo : quo; remainder = neg_r ? -rem : rem, both modulo 2^WIDTH.
  - If dz: quotient = all ones and remainder = src1, regardless of signed_op.
  - Register the result selected by rem_op; assert done for one cycle; return to IDLE.
- Latency: start sampled in cycle 0; busy=1 in cycles 1..WIDTH+2; done=1 in cycle WIDTH+3 (cycle 35 for WIDTH=32).
- A new start is accepted in the done cycle.
- Signed overflow: -2^(WIDTH-1) / -1 gives quotient 0x80000000 and remainder 0 (natural wrap, no flag).
- Rounding: truncation toward zero; the remainder takes the sign of the dividend.
- abort=1 in any state: next state IDLE, busy=0; done is suppressed in that cycle; result retains its previous value.
- abort together with start in IDLE: abort wins; no operation starts.
- Asynchronous reset mid-operation: immediate return to IDLE with outputs at their reset values.

Optional Feature:
- Macro: NIOS2_DIV_EARLY_OUT_EN.
- Defined:
  - In PREP, if dz=0 and |src1| < |src2| (unsigned compare), skip ITER: quo=0, rem=|src1|, next state FIXUP.
  - done then arrives in cycle 3. The sign and rem_op rules above still apply.
- Undefined: every operation takes WIDTH+3 cycles. The comparator is not built.

Decomposition:
- Package nios2_div_pkg holds:
  - the state enum (IDLE, PREP, ITER, FIXUP);
  - localparam DIV_LATENCY = WIDTH+3;
  - localparam DIV_EARLY_LATENCY = 3;
  - the count width function clog2(WIDTH).
- Sub-module nios2_div_step, purely combinational: one restoring iteration. Inputs are rem, quo and divisor; outputs are next rem and next quo. It is instantiated once, in ITER.

Test Plan:
- Unsigned 100 / 7: rem_op=0 gives result=14; rem_op=1 gives result=2. done in cycle 35; busy high in cycles 1..34.
- Signed -7 / 2: quotient=0xFFFFFFFD; remainder=0xFFFFFFFF. Signed 7 / -2: quotient=0xFFFFFFFD; remainder=1.
- Divide by zero, src1=0x12345678, src2=0, signed and unsigned: quotient=0xFFFFFFFF; remainder=0x12345678.
- Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. Unsigned same operands: quotient=0, remainder=0x80000000 (cycle 3 with early-out).
- abort at cycle 10 of a divide: busy=0 from the next cycle; no done pulse; result unchanged. Also: start while busy is ignored; start in the done cycle is accepted.
- 5 / 9 unsigned: quotient=0, remainder=5. done at cycle 3 with NIOS2_DIV_EARLY_OUT_EN defined, cycle 35 without.
